// File: rtl/rv32_mem_loader_if.sv
// Stream and memory-write bundle of the rv32 memory loader.
// The loader is the stream slave and drives the memory-write side.
interface rv32_mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/rv32_mem_loader.sv
// Framed byte-stream loader: packs ADDR/LEN/payload frames into little-endian
// word writes and holds the core in reset until a LEN==0 frame arrives.
module rv32_mem_loader #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic             clk,
  input  logic             reset,
  rv32_mem_loader_if.slave bus,
  output logic             core_reset_n,
  output logic             load_done,
  output logic             load_err
);
  localparam logic [31:0] WIN_BYTES = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    HDR_ADDR = 2'd0,
    HDR_LEN  = 2'd1,
    DATA     = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] base_q, base_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [3:0]  wbe_q, wbe_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        core_reset_n_q, core_reset_n_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q, load_err_d;

  logic        accept_s;
  logic        in_win_s;
  logic        last_byte_s;
  logic        issue_s;
  logic [1:0]  lane_s;
  logic [31:0] len_full_s;
  logic [31:0] word_s;
  logic [3:0]  be_s;

  // Per-byte datapath: window test, lane merge and write-issue decision.
  always_comb begin
    accept_s    = bus.in_valid & in_ready_q;
    lane_s      = cur_addr_q[1:0];
    in_win_s    = (cur_addr_q - MEM_BASE) < WIN_BYTES;
    last_byte_s = (remaining_q == 32'd1);
    issue_s     = (lane_s == 2'd3) | last_byte_s;
    // The 4th LEN byte is still on the bus, so the full length is assembled here.
    len_full_s  = {bus.in_data, remaining_q[23:0]};
    word_s      = wbuf_q;
    word_s[{lane_s, 3'b000} +: 8] = bus.in_data;
    be_s        = wbe_q | (in_win_s ? (4'b0001 << lane_s) : 4'b0000);
  end

  // Frame parser and write generator.
  always_comb begin
    state_d        = state_q;
    hdr_cnt_d      = hdr_cnt_q;
    base_d         = base_q;
    remaining_d    = remaining_q;
    cur_addr_d     = cur_addr_q;
    wbuf_d         = wbuf_q;
    wbe_d          = wbe_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    core_reset_n_d = core_reset_n_q;
    load_done_d    = load_done_q;
    load_err_d     = load_err_q;

    if (accept_s) begin
      case (state_q)
        HDR_ADDR: begin
          base_d[{hdr_cnt_q, 3'b000} +: 8] = bus.in_data;
          if (hdr_cnt_q == 2'd3) begin
            state_d   = HDR_LEN;
            hdr_cnt_d = 2'd0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
          end
        end
        HDR_LEN: begin
          remaining_d[{hdr_cnt_q, 3'b000} +: 8] = bus.in_data;
          if (hdr_cnt_q == 2'd3) begin
            hdr_cnt_d = 2'd0;
            if (len_full_s == 32'd0) begin
              state_d        = DONE;
              load_done_d    = 1'b1;
              core_reset_n_d = 1'b1;
            end else begin
              state_d    = DATA;
              cur_addr_d = base_q;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
          end
        end
        DATA: begin
          cur_addr_d  = cur_addr_q + 32'd1;
          remaining_d = remaining_q - 32'd1;
          load_err_d  = load_err_q | ~in_win_s;
          if (issue_s) begin
            // A word whose lanes all fell outside the window produces no strobe.
            mem_we_d    = |be_s;
            mem_addr_d  = {cur_addr_q[31:2], 2'b00};
            mem_wdata_d = word_s;
            mem_be_d    = be_s;
            wbuf_d      = 32'd0;
            wbe_d       = 4'd0;
          end else begin
            wbuf_d = word_s;
            wbe_d  = be_s;
          end
          if (last_byte_s) begin
            state_d   = HDR_ADDR;
            hdr_cnt_d = 2'd0;
          end else begin
            state_d = DATA;
          end
        end
        default: begin
          state_d = DONE;
        end
      endcase
    end else begin
      mem_we_d = 1'b0;
    end

    in_ready_d = (state_d != DONE);
  end

  // State and registered outputs; reset discards any partially built word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= HDR_ADDR;
      hdr_cnt_q      <= 2'd0;
      base_q         <= 32'd0;
      remaining_q    <= 32'd0;
      cur_addr_q     <= 32'd0;
      wbuf_q         <= 32'd0;
      wbe_q          <= 4'd0;
      in_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_wdata_q    <= 32'd0;
      mem_be_q       <= 4'd0;
      core_reset_n_q <= 1'b0;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_cnt_q      <= hdr_cnt_d;
      base_q         <= base_d;
      remaining_q    <= remaining_d;
      cur_addr_q     <= cur_addr_d;
      wbuf_q         <= wbuf_d;
      wbe_q          <= wbe_d;
      in_ready_q     <= in_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      core_reset_n_q <= core_reset_n_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign core_reset_n  = core_reset_n_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
endmodule

// File: doc/rv32_mem_loader.md
# rv32_mem_loader

Byte-stream memory loader for the rv32 single-cycle system: the write-side counterpart to the bench-side memory dump. It receives framed bytes on a valid/ready stream, packs them into 32-bit little-endian words with byte enables, and writes them into the unified instruction/data memory. It holds the core in reset until a terminating frame arrives, then releases it.

## Interface
- MEM_BASE, 32'h0000_0000: lowest writable byte address.
- MEM_BYTES, 8192: size of the writable window in bytes. Valid addresses are MEM_BASE .. MEM_BASE+MEM_BYTES-1.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle. A byte is accepted when in_valid && in_ready.
- mem_we  out  1  one-cycle word write strobe.
- mem_addr  out  32  word-aligned byte address; bits [1:0] are always 0.
- mem_wdata  out  32  write data, little-endian lanes.
- mem_be  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- core_reset_n  out  1  active-low reset to the core; low until load completes.
- load_done  out  1  sticky; set when the terminating frame is parsed.
- load_err  out  1  sticky; set on any out-of-window byte.

## Operation
- Frame format: ADDR (4 bytes, LSB first), LEN (4 bytes, LSB first, byte count), then LEN payload bytes. Frames repeat back-to-back.
- A frame with LEN==0 terminates loading. Its ADDR bytes are ignored.
- FSM states:
  - HDR_ADDR: collect 4 bytes into base; go to HDR_LEN.
  - HDR_LEN: collect 4 bytes into remaining. If remaining==0, go to DONE; otherwise load cur_addr=base and go to DATA.
  - DATA: place each byte in lane cur_addr[1:0] of the word buffer and set that lane's enable.
    - A write issues when the lane is 3 or the byte is the last of the frame (remaining==1).
    - On the last byte, go to HDR_ADDR.
  - DONE: terminal until reset.
- A header byte counter (0..3) selects the byte position in ADDR/LEN. It clears on every state entry.
- cur_addr increments by 1 per payload byte and wraps modulo 2^32. remaining decrements by 1 per payload byte.
- Unaligned base: the first word carries only the lanes from base[1:0] upward. A trailing partial word carries only the lanes written.
- Out-of-window byte (cur_addr - MEM_BASE >= MEM_BYTES, unsigned 32-bit compare):
  - its lane enable is not set and load_err is set;
  - the byte is still consumed and counted.
  - If no lanes are enabled at write time, mem_we stays 0 for that word.
- in_ready is 1 in HDR_ADDR, HDR_LEN and DATA, and 0 in DONE and during reset.
- The loader never stalls the stream otherwise. The memory accepts a write every cycle.

## Timing
- Reset values: in_ready=0 while reset is asserted, then 1 from the first clk edge after deassertion. mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, core_reset_n=0, load_done=0, load_err=0. State is HDR_ADDR with all counters 0.
- Write latency: a byte accepted at edge N that completes a word produces mem_we=1 with that word during the cycle after edge N, for exactly one cycle.
- The word buffer and enables clear at the same edge, so back-to-back bytes continue without a bubble.
- A last-byte write and the following frame's first ADDR byte may be accepted on consecutive edges.
- Entering DONE: load_done=1 and core_reset_n=1 in the cycle after the 4th LEN byte is accepted. Both stay there until reset.
- Reset mid-frame: all state is discarded immediately (asynchronous) and any pending write is dropped. Loading restarts at HDR_ADDR.
- Bytes offered while in DONE are not accepted (in_ready=0).

## Test plan
- Aligned load: frame ADDR=0x400, LEN=8, bytes 11..18, then a terminator frame.
  - Writes: 0x400 / 0x14131211 / be=F, then 0x404 / 0x18171615 / be=F, each one cycle after its 4th byte.
  - core_reset_n rises one cycle after the last LEN byte.
- Unaligned and partial: ADDR=0x402, LEN=3, bytes AA BB CC.
  - Writes: 0x400 / be=1100 / lanes 2,3 = AA,BB, then 0x404 / be=0001 / lane 0 = CC.
- Stream gaps and back-to-back frames:
  - Randomly deassert in_valid across two consecutive frames (0x0 / LEN 4 and 0x10 / LEN 4).
  - Required: exactly two writes with correct data, no dropped or duplicated bytes, in_ready constantly 1.
- Out of window: MEM_BYTES=8192, ADDR=0x1FFE, LEN=4.
  - One write: 0x1FFC / be=1100.
  - The second word is suppressed (mem_we never asserted for 0x2000).
  - load_err=1; load still completes after the terminator.
- Reset mid-payload: assert reset after 2 of 4 payload bytes.
  - Required: no mem_we, all outputs at reset values.
  - A subsequent complete load behaves as in the aligned-load test.
- DONE lockout: after the terminator, hold in_valid=1 for 10 cycles.
  - Required: in_ready=0, no writes, load_done and core_reset_n stay 1.
